// File: rtl/mux_select_arbiter.sv
// Round-robin owner of the one-hot mux select bus with a break-before-make gap.
// Optional forced release of long grants: define GRANT_TIMEOUT_EN.
module mux_select_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DONE,
    output logic [NUM_REQ-1:0] GNT,
    output logic [ADDR_W-1:0]  ADDR,
    output logic               BUSY,
    output logic               TIMEOUT
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;

    logic [NUM_REQ-1:0] rot;
    logic               pick_vld;
    logic [IW-1:0]      pick_off;
    logic [IW:0]        pick_sum;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IW:0]        nxt_sum;
    logic [IW-1:0]      nxt_ptr;
    logic               others;
    logic               hold_hit;
    logic               force_rel;
    logic               rel_now;

    // Requests rotated so bit 0 is the requester at the pointer.
    assign rot = NUM_REQ'({REQ, REQ} >> ptr);

    always_comb begin
        pick_vld = 1'b0;
        pick_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_vld = 1'b1;
                pick_off = IW'(k);
            end
        end
    end

    assign pick_sum = {1'b0, ptr} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= NR) ? IW'(pick_sum - NR)
                                       : IW'(pick_sum);
    assign pick_oh  = NUM_REQ'(1) << pick_idx;

    assign nxt_sum = {1'b0, owner} + (IW+1)'(1);
    assign nxt_ptr = (nxt_sum >= NR) ? '0 : IW'(nxt_sum);

    assign others = |(REQ & ~(NUM_REQ'(1) << owner));

`ifdef GRANT_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HMAX = CW'(MAX_HOLD - 1);
    logic [CW-1:0] hold;
    assign hold_hit = (hold == HMAX);
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
    assign hold_hit = 1'b0;
`endif

    // A timeout only counts when the owner still wants the mux.
    assign force_rel = hold_hit && others && REQ[owner] && !DONE[owner];
    assign rel_now   = !REQ[owner] || DONE[owner] || force_rel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            GNT     <= '0;
            ADDR    <= '0;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            hold    <= '0;
`endif
        end else begin
            TIMEOUT <= 1'b0;
            unique case (state)
                IDLE, RELEASE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        GNT   <= pick_oh;
                        ADDR  <= ADDR_W'(pick_oh);
                        BUSY  <= 1'b1;
                        state <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                        hold  <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        GNT     <= '0;
                        ADDR    <= '0;
                        BUSY    <= 1'b0;
                        ptr     <= nxt_ptr;
                        TIMEOUT <= force_rel;
                        state   <= RELEASE;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else if (!hold_hit) begin
                        hold <= hold + CW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
